// File: rtl/div_meas_pkg.sv
// div_meas_pkg: state encodings, default parameters and a saturating
// increment shared by the clk_div_meas files.
package div_meas_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_HIGH = HIGH,
    S_LOW  = LOW
  } state_t;

  localparam int DEF_W       = 16;
  localparam int DEF_TIMEOUT = 1000;
  localparam int DEF_LOCK_N  = 4;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] lim
  );
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/div_meas_edge.sv
// div_meas_edge: samples clk_in and derives rise/fall strobes.
// `DIV_MEAS_SYNC_EN adds a 2-flop synchronizer ahead of the sampler.
module div_meas_edge
  import div_meas_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic src;
  logic s_d;

`ifdef DIV_MEAS_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[0], clk_in};
  end

  assign src = sync[1];
`else
  assign src = clk_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= 1'b0;
      s_d <= 1'b0;
    end else begin
      s   <= src;
      s_d <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/clk_div_meas.sv
// clk_div_meas: measures period/high/low of a divided clock in clk cycles,
// flags lock and stall. Optional input synchronizer: `DIV_MEAS_SYNC_EN.
module clk_div_meas
  import div_meas_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int LOCK_N  = DEF_LOCK_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_cnt,
  output logic [W-1:0] low_cnt,
  output logic         meas_vld,
  output logic         locked,
  output logic         stall
);

  localparam int LW = $clog2(LOCK_N + 1);
  localparam logic [W-1:0]  TO  = W'(TIMEOUT);
  localparam logic [W-1:0]  ONE = W'(1);
  localparam logic [LW-1:0] LN  = LW'(LOCK_N);

  function automatic logic [W-1:0] inc(input logic [W-1:0] v);
    return W'(sat_inc(32'(v), 32'(TIMEOUT)));
  endfunction

  logic s, rise, fall;

  div_meas_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .clk_in (clk_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  state_t state, state_n;
  logic [W-1:0]  hi_c, lo_c, id_c;
  logic [W-1:0]  hi_n, lo_n, id_n;
  logic [W-1:0]  per_n, hc_n, lc_n, per_new;
  logic [LW-1:0] lock_cnt, lcnt_n;
  logic          vld_n, lk_n, stall_n, tout;

  always_comb begin
    state_n = state;
    hi_n    = hi_c;
    lo_n    = lo_c;
    id_n    = id_c;
    per_n   = period;
    hc_n    = high_cnt;
    lc_n    = low_cnt;
    vld_n   = 1'b0;
    lk_n    = locked;
    lcnt_n  = lock_cnt;
    stall_n = stall;
    tout    = 1'b0;
    per_new = hi_c + lo_c;
    if (rise) stall_n = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rise) begin
          state_n = S_HIGH;
          hi_n    = ONE;
          id_n    = '0;
        end else if (fall) begin
          id_n = ONE;
        end else begin
          id_n = inc(id_c);
          tout = (id_n == TO);
        end
      end
      S_HIGH: begin
        if (fall) begin
          state_n = S_LOW;
          lo_n    = ONE;
        end else if (s) begin
          hi_n = inc(hi_c);
          tout = (hi_n == TO);
        end
      end
      S_LOW: begin
        if (rise) begin
          state_n = S_HIGH;
          hi_n    = ONE;
          hc_n    = hi_c;
          lc_n    = lo_c;
          per_n   = per_new;
          vld_n   = 1'b1;
          // lock_cnt==0 marks the first report since reset or stall
          if (lock_cnt == '0)
            lcnt_n = LW'(1);
          else if (per_new == period)
            lcnt_n = LW'(sat_inc(32'(lock_cnt), 32'(LOCK_N)));
          else
            lcnt_n = LW'(1);
          lk_n = (lcnt_n == LN);
        end else if (!s) begin
          lo_n = inc(lo_c);
          tout = (lo_n == TO);
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (tout) begin
      state_n = S_IDLE;
      stall_n = 1'b1;
      lk_n    = 1'b0;
      lcnt_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_c     <= '0;
      lo_c     <= '0;
      id_c     <= '0;
      period   <= '0;
      high_cnt <= '0;
      low_cnt  <= '0;
      meas_vld <= 1'b0;
      locked   <= 1'b0;
      lock_cnt <= '0;
      stall    <= 1'b0;
    end else begin
      hi_c     <= hi_n;
      lo_c     <= lo_n;
      id_c     <= id_n;
      period   <= per_n;
      high_cnt <= hc_n;
      low_cnt  <= lc_n;
      meas_vld <= vld_n;
      locked   <= lk_n;
      lock_cnt <= lcnt_n;
      stall    <= stall_n;
    end
  end

endmodule

// File: tb/tb_clk_div_meas.sv
// tb_clk_div_meas: directed and random clk_in waveforms checked against
// a run-length model of the divided clock.
module tb_clk_div_meas;

  localparam int W  = 16;
  localparam int TO = 40;
  localparam int LN = 4;
`ifdef DIV_MEAS_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk;
  logic         rst;
  logic         clk_in;
  logic [W-1:0] period, high_cnt, low_cnt;
  logic         meas_vld, locked, stall;

  clk_div_meas #(.W(W), .TIMEOUT(TO), .LOCK_N(LN)) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_in   (clk_in),
    .period   (period),
    .high_cnt (high_cnt),
    .low_cnt  (low_cnt),
    .meas_vld (meas_vld),
    .locked   (locked),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int    n_chk = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  string step = "init";

  // model: sample pipe, current run length, transitions since idle
  int pipe [0:3];
  int runlen, ntr, hlen;
  int per_q [$];
  int e_per, e_hi, e_lo;
  bit e_vld, e_lock, e_stall;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk({step, "/vld"},   32'(meas_vld), 32'(e_vld));
    chk({step, "/per"},   32'(period),   32'(e_per));
    chk({step, "/hi"},    32'(high_cnt), 32'(e_hi));
    chk({step, "/lo"},    32'(low_cnt),  32'(e_lo));
    chk({step, "/lock"},  32'(locked),   32'(e_lock));
    chk({step, "/stall"}, 32'(stall),    32'(e_stall));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) pipe[i] = 0;
    runlen = 0; ntr = 0; hlen = 0;
    per_q.delete();
    e_per = 0; e_hi = 0; e_lo = 0;
    e_vld = 0; e_lock = 0; e_stall = 0;
  endtask

  function automatic bit all_same();
    if (per_q.size() < LN) return 1'b0;
    foreach (per_q[i]) if (per_q[i] != per_q[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit v);
    int a, b;
    a = pipe[LAT];
    b = pipe[LAT+1];
    e_vld = 0;
    if (a != b) begin
      if (a == 1) begin
        e_stall = 0;
        if (ntr >= 2) begin
          e_hi  = hlen;
          e_lo  = runlen;
          e_per = hlen + runlen;
          e_vld = 1;
          per_q.push_back(e_per);
          if (per_q.size() > LN) void'(per_q.pop_front());
          e_lock = all_same();
        end
        ntr++;
      end else if (ntr > 0) begin
        hlen = runlen;
        ntr++;
      end
      runlen = 1;
    end else begin
      runlen++;
    end
    if (runlen >= TO) begin
      e_stall = 1;
      e_lock  = 0;
      ntr     = 0;
      per_q.delete();
    end
    for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = int'(v);
  endtask

  task automatic cyc(input bit v);
    clk_in = v;
    @(posedge clk);
    if (!rst) model_edge(v);
    #1;
    check_all();
  endtask

  task automatic phase(input bit v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  initial begin
    int nv, n8, got, got2, last, h, l, reps;
    rst = 1'b1;
    clk_in = 1'b0;
    model_reset();
    #15;
    step = "reset";
    check_all();
    #85;
    rst = 1'b0;

    step = "t1_div4";
    nv = 0;
    for (int j = 1; j <= 40; j++) begin
      cyc(((j - 1) % 4) < 2);
      if (meas_vld) begin
        nv++;
        chk("t1_per", 32'(period), 4);
        chk("t1_hi", 32'(high_cnt), 2);
        chk("t1_lo", 32'(low_cnt), 2);
        if (nv == 1) chk("t1_first_vld", j, 6 + LAT);
        if (nv == 3) chk("t1_unlocked3", 32'(locked), 0);
        if (nv == 4) chk("t1_locked4", 32'(locked), 1);
      end
    end
    chk("t1_nvld", nv, (40 - 6 - LAT) / 4 + 1);

    step = "t2_div5";
    nv = 0;
    last = 0;
    for (int j = 1; j <= 30; j++) begin
      cyc(((j - 1) % 5) < 3);
      if (meas_vld) begin
        nv++;
        if (nv >= 2) begin
          chk("t2_per", 32'(period), 5);
          chk("t2_hi", 32'(high_cnt), 3);
          chk("t2_lo", 32'(low_cnt), 2);
          chk("t2_gap", j - last, 5);
        end
        last = j;
      end
    end

    step = "t3_div4";
    for (int j = 1; j <= 12; j++) cyc(((j - 1) % 4) < 2);
    phase(1, 2);
    step = "t3_hold_low";
    got = 0;
    for (int j = 1; j <= TO + 10; j++) begin
      cyc(0);
      if (stall && got == 0) got = j;
    end
    chk("t3_stall_delay", got, TO + LAT + 1);
    chk("t3_locked", 32'(locked), 0);
    chk("t3_per", 32'(period), 4);
    chk("t3_hi", 32'(high_cnt), 2);
    chk("t3_lo", 32'(low_cnt), 2);
    step = "t3_restart";
    got = 0;
    got2 = 0;
    for (int j = 1; j <= 12; j++) begin
      cyc(((j - 1) % 4) < 2);
      if (!stall && got == 0) got = j;
      if (meas_vld && got2 == 0) got2 = j;
    end
    chk("t3_stall_clear", got, 2 + LAT);
    chk("t3_first_vld", got2, 6 + LAT);

    step = "t4_div4";
    for (int j = 1; j <= 24; j++) cyc(((j - 1) % 4) < 2);
    step = "t4_div8";
    n8 = 0;
    for (int j = 1; j <= 48; j++) begin
      cyc(((j - 1) % 8) < 4);
      if (meas_vld && period == 8) begin
        n8++;
        if (n8 == 1) chk("t4_unlock", 32'(locked), 0);
        if (n8 == 3) chk("t4_unlocked3", 32'(locked), 0);
        if (n8 == 4) chk("t4_relock", 32'(locked), 1);
      end
    end
    chk("t4_n8", n8, 5);

    step = "t5_pre";
    for (int j = 1; j <= 12; j++) cyc(((j - 1) % 4) < 2);
    cyc(1);
    #4;
    rst = 1'b1;
    #1;
    model_reset();
    step = "t5_async";
    check_all();
    step = "t5_hold";
    cyc(0);
    cyc(0);
    rst = 1'b0;
    step = "t5_after";
    got = 0;
    for (int j = 1; j <= 20; j++) begin
      cyc(((j - 1) % 4) < 2);
      if (meas_vld && got == 0) got = j;
    end
    chk("t5_first_vld", got, 6 + LAT);

    step = "rand";
    for (int k = 0; k < 30; k++) begin
      h = $urandom_range(1, 10);
      l = $urandom_range(1, 10);
      reps = $urandom_range(1, 6);
      for (int r = 0; r < reps; r++) begin
        phase(1, h);
        phase(0, l);
      end
      if ($urandom_range(0, 7) == 0) phase(0, TO + $urandom_range(0, 5));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
